bp_update_queue: RTL and testbench

In-order queue of in-flight branch predictions, sitting between the fetch-side predictor and the execute stage. Each predicted branch/jump is pushed at fetch and popped when execute resolves it. On each pop the block emits the predictor training triple (`ex_br_valid/taken/instr_addr`) one cycle later. It also detects mispredictions and produces a registered redirect plus a flush of all younger entries.

---
 rtl/bp_update_queue.sv | 142 ++++++++++++++
 tb/tb_bp_update_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_queue.sv
// In-order queue of in-flight branch predictions with training, redirect and flush.
// Optional perf counters are enabled by defining BP_UPDQ_PERF_EN.
module bp_update_queue #(
    parameter int Depth = 4,
    parameter int PcW   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pred_valid_i,
    output logic                       pred_ready_o,
    input  logic [PcW-1:0]             pred_pc_i,
    input  logic                       pred_c_i,
    input  logic                       pred_taken_i,
    input  logic [PcW-1:0]             pred_target_i,
    input  logic                       res_valid_i,
    input  logic                       res_taken_i,
    input  logic [PcW-1:0]             res_target_i,
    input  logic                       flush_i,
    output logic                       ex_br_valid_o,
    output logic                       ex_br_taken_o,
    output logic [PcW-1:0]             ex_br_instr_addr_o,
    output logic                       mispredict_o,
    output logic [PcW-1:0]             redirect_pc_o,
    output logic                       orphan_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic [31:0]                branch_cnt_o,
    output logic [31:0]                mispred_cnt_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(Depth);

    logic [PcW-1:0] pc_mem     [Depth];
    logic           c_mem      [Depth];
    logic           taken_mem  [Depth];
    logic [PcW-1:0] target_mem [Depth];

    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [CW-1:0]  count;

    logic           push;
    logic           pop;
    logic           mis;
    logic           redirect_en;
    logic [PcW-1:0] head_pc;
    logic           head_c;
    logic           head_taken;
    logic [PcW-1:0] head_target;
    logic [PcW-1:0] fall_pc;
    logic [PcW-1:0] redirect_next;

    assign pred_ready_o = (count != FULL);
    assign count_o      = count;

    always_comb begin
        push          = pred_valid_i & pred_ready_o;
        pop           = res_valid_i & (count != '0);
        head_pc       = pc_mem[head];
        head_c        = c_mem[head];
        head_taken    = taken_mem[head];
        head_target   = target_mem[head];
        mis           = pop & ((res_taken_i != head_taken) |
                               (res_taken_i & head_taken & (res_target_i != head_target)));
        redirect_en   = mis & ~flush_i;
        fall_pc       = head_pc + (head_c ? PcW'(2) : PcW'(4));
        redirect_next = res_taken_i ? res_target_i : fall_pc;
    end

    // Storage needs no reset: head/tail/count decide what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[tail]     <= pred_pc_i;
            c_mem[tail]      <= pred_c_i;
            taken_mem[tail]  <= pred_taken_i;
            target_mem[tail] <= pred_target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i | mis) begin
            // Any same-cycle push is wrong-path: tail is left untouched.
            head  <= tail;
            count <= '0;
        end else begin
            if (pop)  head <= head + 1'b1;
            if (push) tail <= tail + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_br_valid_o      <= 1'b0;
            ex_br_taken_o      <= 1'b0;
            ex_br_instr_addr_o <= '0;
            mispredict_o       <= 1'b0;
            redirect_pc_o      <= '0;
            orphan_o           <= 1'b0;
        end else begin
            ex_br_valid_o <= pop;
            mispredict_o  <= redirect_en;
            orphan_o      <= res_valid_i & (count == '0);
            if (pop) begin
                ex_br_taken_o      <= res_taken_i;
                ex_br_instr_addr_o <= head_pc;
            end
            if (redirect_en) redirect_pc_o <= redirect_next;
        end
    end

`ifdef BP_UPDQ_PERF_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (pop && branch_cnt != '1)          branch_cnt  <= branch_cnt + 1'b1;
            if (redirect_en && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

    assign branch_cnt_o  = branch_cnt;
    assign mispred_cnt_o = mispred_cnt;
`else
    assign branch_cnt_o  = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// Scoreboard bench for bp_update_queue: queue-based reference model,
// directed scenarios then randomized traffic.
module tb_bp_update_queue;

    localparam int DEPTH = 4;
    localparam int PCW   = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            pred_valid_i;
    logic            pred_ready_o;
    logic [PCW-1:0]  pred_pc_i;
    logic            pred_c_i;
    logic            pred_taken_i;
    logic [PCW-1:0]  pred_target_i;
    logic            res_valid_i;
    logic            res_taken_i;
    logic [PCW-1:0]  res_target_i;
    logic            flush_i;
    logic            ex_br_valid_o;
    logic            ex_br_taken_o;
    logic [PCW-1:0]  ex_br_instr_addr_o;
    logic            mispredict_o;
    logic [PCW-1:0]  redirect_pc_o;
    logic            orphan_o;
    logic [2:0]      count_o;
    logic [31:0]     branch_cnt_o;
    logic [31:0]     mispred_cnt_o;

    bp_update_queue #(.Depth(DEPTH), .PcW(PCW)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .pred_valid_i       (pred_valid_i),
        .pred_ready_o       (pred_ready_o),
        .pred_pc_i          (pred_pc_i),
        .pred_c_i           (pred_c_i),
        .pred_taken_i       (pred_taken_i),
        .pred_target_i      (pred_target_i),
        .res_valid_i        (res_valid_i),
        .res_taken_i        (res_taken_i),
        .res_target_i       (res_target_i),
        .flush_i            (flush_i),
        .ex_br_valid_o      (ex_br_valid_o),
        .ex_br_taken_o      (ex_br_taken_o),
        .ex_br_instr_addr_o (ex_br_instr_addr_o),
        .mispredict_o       (mispredict_o),
        .redirect_pc_o      (redirect_pc_o),
        .orphan_o           (orphan_o),
        .count_o            (count_o),
        .branch_cnt_o       (branch_cnt_o),
        .mispred_cnt_o      (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        bit          c;
        bit          taken;
        logic [31:0] target;
    } ent_t;

    typedef struct {
        int          due;
        bit          train;
        bit          taken;
        logic [31:0] addr;
        bit          mis;
        logic [31:0] redir;
        bit          orphan;
    } exp_t;

    ent_t        q[$];
    exp_t        expq[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_br = 0;
    logic [31:0] m_mis = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT pulses against the scoreboard whenever one is due.
    always @(negedge clk_i) begin
        bit   any;
        exp_t e;
        any = (ex_br_valid_o === 1'b1) || (mispredict_o === 1'b1) || (orphan_o === 1'b1);
        if (expq.size() != 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("ex_br_valid", 32'(ex_br_valid_o), 32'(e.train));
            chk("mispredict", 32'(mispredict_o), 32'(e.mis));
            chk("orphan", 32'(orphan_o), 32'(e.orphan));
            if (e.train) begin
                chk("ex_br_taken", 32'(ex_br_taken_o), 32'(e.taken));
                chk("ex_br_addr", ex_br_instr_addr_o, e.addr);
            end
            if (e.mis) chk("redirect_pc", redirect_pc_o, e.redir);
        end else if (any) begin
            chk("spurious_pulse", {29'd0, ex_br_valid_o, mispredict_o, orphan_o}, 32'd0);
        end
    end

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(input bit r, input bit pv, input logic [31:0] pc, input bit c,
                        input bit pt, input logic [31:0] ptgt, input bit rv, input bit rt,
                        input logic [31:0] rtgt, input bit fl);
        exp_t e;
        ent_t n;
        bit   push_ok;
        bit   mis;
        chk("count", 32'(count_o), 32'(q.size()));
        chk("pred_ready", 32'(pred_ready_o), 32'(q.size() != DEPTH));
`ifdef BP_UPDQ_PERF_EN
        chk("branch_cnt", branch_cnt_o, m_br);
        chk("mispred_cnt", mispred_cnt_o, m_mis);
`else
        chk("branch_cnt", branch_cnt_o, 32'd0);
        chk("mispred_cnt", mispred_cnt_o, 32'd0);
`endif
        rst_i = r; pred_valid_i = pv; pred_pc_i = pc; pred_c_i = c;
        pred_taken_i = pt; pred_target_i = ptgt; res_valid_i = rv;
        res_taken_i = rt; res_target_i = rtgt; flush_i = fl;

        if (r) begin
            q.delete();
            m_br = 0;
            m_mis = 0;
        end else begin
            push_ok = pv && (q.size() < DEPTH);
            mis = 0;
            if (rv) begin
                e = '{due: cyc + 1, train: 0, taken: 0, addr: 0, mis: 0, redir: 0, orphan: 0};
                if (q.size() == 0) begin
                    e.orphan = 1;
                end else begin
                    e.train = 1;
                    e.taken = rt;
                    e.addr  = q[0].pc;
                    mis = (rt != q[0].taken) || (rt && rtgt != q[0].target);
                    e.mis = mis && !fl;
                    e.redir = rt ? rtgt : q[0].pc + (q[0].c ? 32'd2 : 32'd4);
                    if (m_br != 32'hFFFF_FFFF) m_br++;
                    if (e.mis && m_mis != 32'hFFFF_FFFF) m_mis++;
                end
                expq.push_back(e);
            end
            if (fl || mis) begin
                q.delete();
            end else begin
                if (rv && q.size() != 0) void'(q.pop_front());
                if (push_ok) begin
                    n = '{pc: pc, c: c, taken: pt, target: ptgt};
                    q.push_back(n);
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input bit c, input bit pt, input logic [31:0] tgt);
        step(0, 1, pc, c, pt, tgt, 0, 0, 0, 0);
    endtask

    task automatic resolve(input bit rt, input logic [31:0] rtgt);
        step(0, 0, 0, 0, 0, 0, 1, rt, rtgt, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] tgts [2];
        bit r, pv, c, pt, rv, rt, fl;
        logic [31:0] pc, ptgt, rtgt;
        tgts[0] = 32'h1000;
        tgts[1] = 32'h2000;

        rst_i = 1; pred_valid_i = 0; pred_pc_i = 0; pred_c_i = 0; pred_taken_i = 0;
        pred_target_i = 0; res_valid_i = 0; res_taken_i = 0; res_target_i = 0; flush_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(pred_ready_o), 32'd1);
        chk("rst_ex_valid", 32'(ex_br_valid_o), 32'd0);
        chk("rst_ex_taken", 32'(ex_br_taken_o), 32'd0);
        chk("rst_ex_addr", ex_br_instr_addr_o, 32'd0);
        chk("rst_mispredict", 32'(mispredict_o), 32'd0);
        chk("rst_redirect", redirect_pc_o, 32'd0);
        chk("rst_orphan", 32'(orphan_o), 32'd0);
        chk("rst_branch_cnt", branch_cnt_o, 32'd0);
        chk("rst_mispred_cnt", mispred_cnt_o, 32'd0);

        // Fill, confirm full, drain in order.
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 0, 0, 0);
        chk("full_ready", 32'(pred_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) resolve(0, 0);
        chk("drained_count", 32'(count_o), 32'd0);

        // Wrong target on a taken branch flushes the younger entry.
        push(32'h200, 0, 1, 32'h280);
        push(32'h204, 1, 0, 0);
        resolve(1, 32'h2C0);
        chk("tgt_mis_pulse", 32'(mispredict_o), 32'd1);
        chk("tgt_mis_redirect", redirect_pc_o, 32'h2C0);
        chk("tgt_mis_count", 32'(count_o), 32'd0);

        // Predicted taken, actually not taken, compressed fall-through.
        push(32'h300, 1, 1, 32'h380);
        resolve(0, 0);
        chk("nt_redirect", redirect_pc_o, 32'h302);
        chk("nt_ex_taken", 32'(ex_br_taken_o), 32'd0);

        // Resolve on empty queue with a same-cycle push.
        step(0, 1, 32'h400, 0, 0, 0, 1, 0, 0, 0);
        chk("orphan_pulse", 32'(orphan_o), 32'd1);
        chk("orphan_no_train", 32'(ex_br_valid_o), 32'd0);
        chk("orphan_count", 32'(count_o), 32'd1);
        resolve(0, 0);

        // Flush beats mispredict and the same-cycle push.
        push(32'h500, 0, 1, 32'h540);
        push(32'h504, 0, 0, 0);
        push(32'h508, 0, 0, 0);
        step(0, 1, 32'h600, 0, 0, 0, 1, 0, 0, 1);
        chk("flush_train", 32'(ex_br_valid_o), 32'd1);
        chk("flush_addr", ex_br_instr_addr_o, 32'h500);
        chk("flush_no_mis", 32'(mispredict_o), 32'd0);
        chk("flush_count", 32'(count_o), 32'd0);

        // Counter scenario: 10 resolves, first 3 mispredicted.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            push(32'h700 + 32'(4 * i), 0, 0, 0);
            resolve(i < 3, 32'h900);
        end
        idle();
`ifdef BP_UPDQ_PERF_EN
        chk("perf_branch", branch_cnt_o, 32'd10);
        chk("perf_mispred", mispred_cnt_o, 32'd3);
`else
        chk("perf_branch_off", branch_cnt_o, 32'd0);
        chk("perf_mispred_off", mispred_cnt_o, 32'd0);
`endif

        // Randomized traffic, including mid-run resets and PC wrap.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 49) == 0);
            pv = ($urandom_range(0, 2) != 0);
            pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : ($urandom() & 32'hFFFF_FFFE);
            c  = 1'($urandom());
            pt = 1'($urandom());
            ptgt = tgts[$urandom_range(0, 1)];
            rv = 1'($urandom());
            if (q.size() != 0 && $urandom_range(0, 3) != 0) begin
                rt = q[0].taken;
                rtgt = q[0].target;
            end else begin
                rt = 1'($urandom());
                rtgt = tgts[$urandom_range(0, 1)];
            end
            step(r, pv, pc, c, pt, ptgt, rv, rt, rtgt, fl);
        end

        repeat (3) idle();
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
